// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared UART TX definitions: MMIO addresses, FSM states, defaults
package uart_tx_fifo_pkg;

  localparam logic [31:0] UART_DATA_ADDR   = 32'h1000_0000;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h1000_0004;

  localparam int DEFAULT_CLK_HZ = 12000000;
  localparam int DEFAULT_BAUD   = 115200;
  localparam int DEFAULT_DEPTH  = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered full/empty/level flags
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_next;

  // A push is taken when there is room, or when a pop frees a slot this cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop
  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_next = level - LW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH; flags derived from the next level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter for the MMIO data register
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_HZ = DEFAULT_CLK_HZ,
  parameter int BAUD   = DEFAULT_BAUD,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic          busy,
  output logic          overflow,
  output logic          uart_txd
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  uart_state_t   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_d;
  logic          baud_last;
  logic          pop;
  logic          wr_ok;
  logic [7:0]    head;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_ok),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  // Writes into a full FIFO only survive if the serializer pops in the same cycle
  assign wr_ok     = wr_en && (!full || pop);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state_q != UART_IDLE) || !empty;

  // Next-state, counters and shift register; STOP chains straight into START when data waits
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = UART_START;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      UART_START: begin
        if (baud_last) begin
          state_d = UART_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      UART_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = UART_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      UART_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = UART_START;
            bit_d   = '0;
          end else begin
            state_d = UART_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  // Line level follows the state being entered so uart_txd can be a flop
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      UART_START: txd_d = 1'b0;
      UART_DATA:  txd_d = shift_d[0];
      default:    txd_d = 1'b1;
    endcase
  end

  // Serializer registers and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UART_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      uart_txd <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      uart_txd <= txd_d;
      if (wr_en && !wr_ok) overflow <= 1'b1;
    end
  end

endmodule
